iq_out_fifo20: RTL

// Output buffer directly downstream of the 1024-tap I/Q FIR MAC engine.
// - Accepts parallel 20-bit X/Y result pairs on iv and drives the FIR oe stall input early enough to absorb in-flight MAC results.
// - Emits each pair serially as X then Y.
// - Each output word is 16 bits: the value is scaled, rounded and saturated.
// - A valid/ready handshake connects it to the DAC/host interface.

---
 rtl/iq_out_fifo20_pkg.sv | 12 +
 rtl/iq_round_sat.sv | 39 +++
 rtl/iq_out_fifo20.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/iq_out_fifo20_pkg.sv
// Shared constants and output FSM encoding for the I/Q output FIFO.
package iq_out_fifo20_pkg;
  localparam int P_IW  = 20;
  localparam int P_OW  = 16;
  localparam int P_RND = 1 << (P_IW - P_OW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XOUT,
    ST_YOUT
  } st_t;
endpackage

// File: rtl/iq_round_sat.sv
// Combinational gain shift, round-half-up and saturate from IW to OW bits.
module iq_round_sat
  import iq_out_fifo20_pkg::*;
#(
  parameter int IW = P_IW,
  parameter int OW = P_OW
) (
  input  logic [IW-1:0] i_d,
  input  logic [1:0]    i_sh,
  output logic [OW-1:0] o_q,
  output logic          o_sat
);
  // One guard bit above the 23-bit shifted value so the +RND never wraps
  localparam int EW = IW + 4;
  localparam int FR = IW - OW;
  localparam logic signed [EW-1:0] C_RND = EW'(1 << (FR - 1));
  localparam logic signed [EW-1:0] C_MAX = EW'((1 << (OW - 1)) - 1);
  localparam logic signed [EW-1:0] C_MIN = EW'(-(1 << (OW - 1)));

  logic signed [EW-1:0] w_t;
  logic signed [EW-1:0] w_r;
  logic signed [EW-1:0] w_q;

  assign w_t = $signed({{4{i_d[IW-1]}}, i_d}) <<< i_sh;
  assign w_r = w_t + C_RND;
  assign w_q = w_r >>> FR;

  always_comb begin
    o_q   = w_q[OW-1:0];
    o_sat = 1'b0;
    if (w_q > C_MAX) begin
      o_q   = {1'b0, {(OW-1){1'b1}}};
      o_sat = 1'b1;
    end else if (w_q < C_MIN) begin
      o_q   = {1'b1, {(OW-1){1'b0}}};
      o_sat = 1'b1;
    end
  end
endmodule

// File: rtl/iq_out_fifo20.sv
// Pair FIFO behind the I/Q FIR: serialises X then Y as rounded 16-bit words
// over a valid/ready port and throttles the FIR through oe.
module iq_out_fifo20
  import iq_out_fifo20_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int SLACK = 12,
  parameter int IW    = P_IW,
  parameter int OW    = P_OW
) (
  input  logic          clk,
  input  logic          mrst,
  input  logic [IW-1:0] dix,
  input  logic [IW-1:0] diy,
  input  logic          iv,
  output logic          oe,
  input  logic [1:0]    sh,
  output logic [OW-1:0] dout,
  output logic          sx,
  output logic          ov,
  input  logic          ordy,
  output logic          sat,
  output logic          lost,
  output logic [AW:0]   level
);
  logic [2*IW-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [AW:0]     r_lvl;
  logic            r_oe;
  logic            r_lost;
  st_t             r_st;
  st_t             w_nxt;
  logic [OW-1:0]   r_dout;
  logic            r_sat;
  logic            r_sx;
  logic [OW-1:0]   r_y;
  logic            r_ysat;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [AW:0]     w_lvl_nxt;
  logic [2*IW-1:0] w_rd;
  logic [OW-1:0]   w_qx;
  logic [OW-1:0]   w_qy;
  logic            w_sx;
  logic            w_sy;

  assign w_full    = r_lvl == (AW+1)'(DEPTH);
  assign w_empty   = r_lvl == '0;
  assign w_push    = iv & ~w_full;
  assign w_lvl_nxt = r_lvl + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_rd      = r_mem[r_rp];

  iq_round_sat #(.IW(IW), .OW(OW)) u_rsx (
    .i_d   (w_rd[2*IW-1:IW]),
    .i_sh  (sh),
    .o_q   (w_qx),
    .o_sat (w_sx)
  );

  iq_round_sat #(.IW(IW), .OW(OW)) u_rsy (
    .i_d   (w_rd[IW-1:0]),
    .i_sh  (sh),
    .o_q   (w_qy),
    .o_sat (w_sy)
  );

  // Storage has no reset; the pointers and level make stale contents unreachable
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {dix, diy};
  end

  always_ff @(posedge clk) begin
    if (mrst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_lvl  <= '0;
      r_oe   <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (iv & w_full) r_lost <= 1'b1;
      r_lvl <= w_lvl_nxt;
      r_oe  <= w_lvl_nxt <= (AW+1)'(DEPTH - SLACK);
    end
  end

  always_ff @(posedge clk) begin
    if (mrst) r_st <= ST_IDLE;
    else      r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    w_pop = 1'b0;
    unique case (r_st)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          w_nxt = ST_XOUT;
        end
      end
      ST_XOUT: begin
        if (ordy) w_nxt = ST_YOUT;
      end
      ST_YOUT: begin
        if (ordy) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            w_nxt = ST_XOUT;
          end else begin
            w_nxt = ST_IDLE;
          end
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mrst) begin
      r_dout <= '0;
      r_sat  <= 1'b0;
      r_sx   <= 1'b1;
      r_y    <= '0;
      r_ysat <= 1'b0;
    end else if (w_pop) begin
      r_dout <= w_qx;
      r_sat  <= w_sx;
      r_sx   <= 1'b1;
      r_y    <= w_qy;
      r_ysat <= w_sy;
    end else if (r_st == ST_XOUT && ordy) begin
      r_dout <= r_y;
      r_sat  <= r_ysat;
      r_sx   <= 1'b0;
    end else if (r_st == ST_YOUT && ordy) begin
      r_sat  <= 1'b0;
      r_sx   <= 1'b1;
    end
  end

  assign oe    = r_oe;
  assign ov    = r_st != ST_IDLE;
  assign dout  = r_dout;
  assign sx    = r_sx;
  assign sat   = r_sat;
  assign lost  = r_lost;
  assign level = r_lvl;
endmodule
